// File: rtl/mult_result_buf.sv
// Result collector for the shift-add multiplier chain: FWFT FIFO plus credit-based issue gating.
// Define MULT_RESULT_BUF_OVF_EN to build the sticky overflow detector; otherwise ovf_err is tied low.
module mult_result_buf #(
  parameter int N     = 4,
  parameter int M     = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  output logic             issue_ok,
  input  logic             in_vld,
  input  logic [N+M-1:0]   in_data,
  output logic             out_vld,
  output logic [N+M-1:0]   out_data,
  input  logic             out_rdy,
  output logic [AW:0]      count,
  output logic             ovf_err
);

  localparam int W = N + M;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ZERO_C  = {(AW+1){1'b0}};
  localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_INC = AW'(1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r, wr_ptr_r;
  logic [AW:0]   count_r, in_flight_r;
  logic          out_vld_r, issue_ok_r;
  logic [W-1:0]  out_data_r;

  logic          pop_s, push_s, full_s, issue_ok_nxt_s;
  logic [AW-1:0] rd_ptr_nxt_s, wr_ptr_nxt_s;
  logic [AW:0]   count_nxt_s, in_flight_nxt_s;
  logic [AW+1:0] credit_sum_s;
  logic [W-1:0]  head_nxt_s;

  // Next-state for pointers, occupancy, credits and the registered head view.
  always_comb begin
    pop_s           = out_vld_r & out_rdy;
    full_s          = (count_r == DEPTH_C);
    push_s          = in_vld & (~full_s | pop_s);
    rd_ptr_nxt_s    = rd_ptr_r;
    wr_ptr_nxt_s    = wr_ptr_r;
    count_nxt_s     = count_r;
    in_flight_nxt_s = in_flight_r;
    head_nxt_s      = {W{1'b0}};

    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_INC;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_INC;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + ONE_C;
      2'b01:   count_nxt_s = count_r - ONE_C;
      default: count_nxt_s = count_r;
    endcase

    // Credits saturate both ways so a protocol slip cannot wrap the counter.
    case ({issue, in_vld})
      2'b10: begin
        if (in_flight_r == DEPTH_C) begin
          in_flight_nxt_s = in_flight_r;
        end else begin
          in_flight_nxt_s = in_flight_r + ONE_C;
        end
      end
      2'b01: begin
        if (in_flight_r == ZERO_C) begin
          in_flight_nxt_s = in_flight_r;
        end else begin
          in_flight_nxt_s = in_flight_r - ONE_C;
        end
      end
      default: in_flight_nxt_s = in_flight_r;
    endcase

    // A push into the slot that becomes the head bypasses the storage array.
    if (count_nxt_s == ZERO_C) begin
      head_nxt_s = {W{1'b0}};
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = in_data;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end

    credit_sum_s   = {1'b0, count_nxt_s} + {1'b0, in_flight_nxt_s};
    issue_ok_nxt_s = (credit_sum_s < {1'b0, DEPTH_C});
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r    <= {AW{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      count_r     <= ZERO_C;
      in_flight_r <= ZERO_C;
      out_vld_r   <= 1'b0;
      out_data_r  <= {W{1'b0}};
      issue_ok_r  <= 1'b1;
    end else begin
      rd_ptr_r    <= rd_ptr_nxt_s;
      wr_ptr_r    <= wr_ptr_nxt_s;
      count_r     <= count_nxt_s;
      in_flight_r <= in_flight_nxt_s;
      out_vld_r   <= (count_nxt_s != ZERO_C);
      out_data_r  <= head_nxt_s;
      issue_ok_r  <= issue_ok_nxt_s;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

`ifdef MULT_RESULT_BUF_OVF_EN
  logic ovf_r;

  // Sticky flag for a product arriving with nowhere to go.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (in_vld && full_s && !pop_s) begin
      ovf_r <= 1'b1;
    end
  end

  assign ovf_err = ovf_r;
`else
  assign ovf_err = 1'b0;
`endif

  assign issue_ok = issue_ok_r;
  assign out_vld  = out_vld_r;
  assign out_data = out_data_r;
  assign count    = count_r;

endmodule

// File: tb/tb_mult_result_buf.sv
// Directed self-checking bench for mult_result_buf (default parameters N=M=4, DEPTH=4).
module tb_mult_result_buf;

  logic       clk, rst, issue, issue_ok, in_vld, out_vld, out_rdy, ovf_err;
  logic [7:0] in_data, out_data;
  logic [2:0] count;

  int err_cnt = 0;
  int chk_cnt = 0;

`ifdef MULT_RESULT_BUF_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  mult_result_buf #(.N(4), .M(4), .DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .issue(issue), .issue_ok(issue_ok),
    .in_vld(in_vld), .in_data(in_data), .out_vld(out_vld), .out_data(out_data),
    .out_rdy(out_rdy), .count(count), .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic       gate_exp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] drain3   [4] = '{8'h33, 8'h44, 8'h55, 8'hAA};
  logic [7:0] drain5   [4] = '{8'hF1, 8'hF2, 8'hF3, 8'hF4};

  initial begin
    int  sent, rcvd;
    logic rdy_t;
    rst = 1'b1; issue = 1'b0; in_vld = 1'b0; in_data = 8'h00; out_rdy = 1'b0;
    #3;
    check_eq("rst_count", count, 3'd0);
    check_eq("rst_out_vld", out_vld, 1'b0);
    check_eq("rst_out_data", out_data, 8'h00);
    check_eq("rst_issue_ok", issue_ok, 1'b1);
    check_eq("rst_ovf", ovf_err, 1'b0);
    rst = 1'b0;
    tick();

    // Single product
    issue = 1'b1; tick(); issue = 1'b0;
    check_eq("single_issue_ok", issue_ok, 1'b1);
    tick(); tick(); tick();
    in_vld = 1'b1; in_data = 8'h2D; out_rdy = 1'b1;
    tick();
    in_vld = 1'b0;
    check_eq("single_vld", out_vld, 1'b1);
    check_eq("single_data", out_data, 8'h2D);
    check_eq("single_count1", count, 3'd1);
    tick();
    check_eq("single_vld0", out_vld, 1'b0);
    check_eq("single_count0", count, 3'd0);
    check_eq("single_data0", out_data, 8'h00);
    out_rdy = 1'b0;

    // Credit gating
    for (int i = 0; i < 4; i++) begin
      issue = 1'b1; tick();
      check_eq("gate_issue_ok", issue_ok, gate_exp[i]);
    end
    issue = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; in_data = 8'(8'h11 * (i + 1)); tick();
      check_eq("gate_hold", issue_ok, 1'b0);
    end
    in_vld = 1'b0;
    check_eq("gate_count4", count, 3'd4);
    check_eq("gate_head", out_data, 8'h11);
    out_rdy = 1'b1; tick(); out_rdy = 1'b0;
    check_eq("gate_reopen", issue_ok, 1'b1);
    check_eq("gate_count3", count, 3'd3);
    check_eq("gate_head2", out_data, 8'h22);

    // Full with simultaneous push and pop
    in_vld = 1'b1; in_data = 8'h55; tick();
    check_eq("full_count4", count, 3'd4);
    in_data = 8'hAA; out_rdy = 1'b1;
    check_eq("full_head_before", out_data, 8'h22);
    tick();
    in_vld = 1'b0;
    check_eq("full_count_keep", count, 3'd4);
    check_eq("full_ovf", ovf_err, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_eq("full_drain", out_data, {24'd0, drain3[i]});
      tick();
    end
    out_rdy = 1'b0;
    check_eq("full_empty_vld", out_vld, 1'b0);
    check_eq("full_empty_count", count, 3'd0);

    // Order and pointer wrap with out_rdy toggling
    sent = 0; rcvd = 0; rdy_t = 1'b1;
    for (int cyc = 0; cyc < 100 && rcvd < 10; cyc++) begin
      out_rdy = rdy_t;
      if (sent < 10 && count < 3'd4) begin
        in_vld = 1'b1; in_data = 8'(sent + 1); sent++;
      end else begin
        in_vld = 1'b0;
      end
      if (out_vld && out_rdy) begin
        check_eq("order", out_data, 32'(rcvd + 1));
        rcvd++;
      end
      tick();
      rdy_t = ~rdy_t;
    end
    in_vld = 1'b0; out_rdy = 1'b0;
    check_eq("order_total", rcvd, 10);
    check_eq("order_count0", count, 3'd0);

    // Overflow: fifth product with no pop
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; in_data = drain5[i]; tick();
    end
    in_data = 8'hFF; tick();
    in_vld = 1'b0;
    check_eq("ovf_count", count, 3'd4);
    check_eq("ovf_set", ovf_err, EXP_OVF);
    tick();
    check_eq("ovf_held", ovf_err, EXP_OVF);
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("ovf_drain", out_data, {24'd0, drain5[i]});
      tick();
    end
    out_rdy = 1'b0;
    check_eq("ovf_dropped", out_vld, 1'b0);

    // Reset mid-stream with count=3, in_flight=1
    issue = 1'b1; tick(); tick(); tick(); tick(); issue = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1; in_data = 8'(8'h61 + i); tick();
    end
    in_vld = 1'b0;
    check_eq("mid_count3", count, 3'd3);
    check_eq("mid_gated", issue_ok, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_count", count, 3'd0);
    check_eq("mid_rst_vld", out_vld, 1'b0);
    check_eq("mid_rst_data", out_data, 8'h00);
    check_eq("mid_rst_issue_ok", issue_ok, 1'b1);
    check_eq("mid_rst_ovf", ovf_err, 1'b0);
    rst = 1'b0;
    issue = 1'b1; tick(); issue = 1'b0;
    in_vld = 1'b1; in_data = 8'h3C; tick(); in_vld = 1'b0;
    check_eq("post_vld", out_vld, 1'b1);
    check_eq("post_data", out_data, 8'h3C);
    check_eq("post_count", count, 3'd1);
    out_rdy = 1'b1; tick(); out_rdy = 1'b0;
    check_eq("post_empty", count, 3'd0);
    check_eq("post_issue_ok", issue_ok, 1'b1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
